// File: rtl/axi_inf_pkg.sv
// Shared types and AXI constants for the write-burst controller.
// The awsize helper turns the data width into the AXI beat-size code.
package axi_inf_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CALC,
      ISSUE,
      DRAIN,
      DONE
   } state_t;

   localparam logic [1:0] BURST_INCR    = 2'b01;
   localparam logic [1:0] RESP_OKAY     = 2'b00;
   localparam logic       LOCK_NORMAL   = 1'b0;
   localparam logic [3:0] CACHE_DEFAULT = 4'b0000;
   localparam logic [2:0] PROT_DEFAULT  = 3'b000;
   localparam logic [3:0] QOS_DEFAULT   = 4'b0000;

   function automatic logic [2:0] awsize_for(input int dsize);
      return 3'($clog2(dsize / 8));
   endfunction

endpackage

// File: rtl/axi_len_fifo.sv
// Small synchronous FIFO holding the beat count of each issued burst.
// The W path reads the head to place wlast and pops on the last beat.
module axi_len_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             empty,
   output logic             full,
   output logic [WIDTH-1:0] head
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // A push into a full FIFO is still accepted when the head leaves in the same cycle.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign head  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= bump(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= bump(rd_ptr);
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/axi_inf_write_burst_core.sv
// Splits one long write request into boundary-safe AXI4 INCR bursts,
// limits bursts in flight, places wlast and folds B responses into one status.
module axi_inf_write_burst_core
   import axi_inf_pkg::*;
#(
   parameter int IDSIZE          = 3,
   parameter int ID              = 0,
   parameter int ASIZE           = 32,
   parameter int DSIZE           = 256,
   parameter int LSIZE           = 8,
   parameter int RLSIZE          = 24,
   parameter int MAX_BURST       = 16,
   parameter int MAX_OUTSTANDING = 4,
   parameter int BOUNDARY        = 4096
) (
   input  logic              axi_aclk,
   input  logic              axi_reset,

   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ASIZE-1:0]  req_addr,
   input  logic [RLSIZE-1:0] req_len,
   output logic              req_done,
   output logic              req_err,
   output logic              busy,
   output logic              pull_data_en,

   output logic [IDSIZE-1:0] axi_awid,
   output logic [ASIZE-1:0]  axi_awaddr,
   output logic [LSIZE-1:0]  axi_awlen,
   output logic [2:0]        axi_awsize,
   output logic [1:0]        axi_awburst,
   output logic              axi_awlock,
   output logic [3:0]        axi_awcache,
   output logic [2:0]        axi_awprot,
   output logic [3:0]        axi_awqos,
   output logic              axi_awvalid,
   input  logic              axi_awready,

   input  logic              axi_wvalid,
   input  logic              axi_wready,
   output logic              axi_wlast,

   output logic              axi_bready,
   input  logic [IDSIZE-1:0] axi_bid,
   input  logic [1:0]        axi_bresp,
   input  logic              axi_bvalid
);

   localparam int BPB  = DSIZE / 8;
   localparam int BSH  = $clog2(BPB);
   localparam int OFFW = $clog2(BOUNDARY);
   localparam int OW   = $clog2(MAX_OUTSTANDING) + 1;
   localparam int BLW  = LSIZE + 1;

   localparam logic [OFFW:0] BND_BYTES = (OFFW + 1)'(BOUNDARY);

   state_t            state;
   logic [ASIZE-1:0]  addr;
   logic [RLSIZE-1:0] remaining;
   logic [BLW-1:0]    cur_blen;
   logic [OW-1:0]     outstanding;
   logic              err;

   logic [OW-1:0]     outstanding_next;
   logic              aw_hs;
   logic              b_hs;
   logic              b_match;
   logic              w_hs;
   logic              can_issue;

   logic [OFFW:0]     bnd_bytes;
   logic [31:0]       bnd_beats;
   logic [31:0]       blen_wide;
   logic [BLW-1:0]    blen_calc;

   logic              q_push;
   logic              q_pop;
   logic              q_empty;
   logic              q_full;
   logic [BLW-1:0]    q_head;
   logic [BLW-1:0]    wcnt;

   assign axi_awid    = IDSIZE'(ID);
   assign axi_awsize  = awsize_for(DSIZE);
   assign axi_awburst = BURST_INCR;
   assign axi_awlock  = LOCK_NORMAL;
   assign axi_awcache = CACHE_DEFAULT;
   assign axi_awprot  = PROT_DEFAULT;
   assign axi_awqos   = QOS_DEFAULT;

   assign aw_hs   = axi_awvalid && axi_awready;
   assign b_hs    = axi_bvalid && axi_bready;
   assign b_match = b_hs && (axi_bid == IDSIZE'(ID));
   assign w_hs    = axi_wvalid && axi_wready && !q_empty;

   assign outstanding_next = outstanding + OW'(aw_hs) - OW'(b_match);

   // The queue test only matters for a slave that answers B before the last W beat.
   assign can_issue = (outstanding_next < OW'(MAX_OUTSTANDING)) && (!q_full || q_pop);

   assign axi_bready   = (outstanding != '0);
   assign pull_data_en = !q_empty;
   assign axi_wlast    = !q_empty && (wcnt == q_head - BLW'(1));

   assign q_push = aw_hs;
   assign q_pop  = w_hs && axi_wlast;

   // Burst length is the smallest of what is left, the burst cap and the room to the boundary.
   always_comb begin
      bnd_bytes = BND_BYTES - {1'b0, addr[OFFW-1:0]};
      bnd_beats = 32'(bnd_bytes >> BSH);
      blen_wide = 32'(remaining);
      if (blen_wide > 32'(MAX_BURST)) begin
         blen_wide = 32'(MAX_BURST);
      end
      if (blen_wide > bnd_beats) begin
         blen_wide = bnd_beats;
      end
      blen_calc = BLW'(blen_wide);
   end

   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         state       <= IDLE;
         req_ready   <= 1'b1;
         req_done    <= 1'b0;
         req_err     <= 1'b0;
         busy        <= 1'b0;
         axi_awvalid <= 1'b0;
         axi_awaddr  <= '0;
         axi_awlen   <= '0;
         addr        <= '0;
         remaining   <= '0;
         cur_blen    <= '0;
         outstanding <= '0;
         err         <= 1'b0;
      end else begin
         req_done    <= 1'b0;
         req_err     <= 1'b0;
         outstanding <= outstanding_next;
         if (b_hs && ((axi_bid != IDSIZE'(ID)) || (axi_bresp != RESP_OKAY))) begin
            err <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr      <= req_addr;
                  remaining <= req_len;
                  err       <= 1'b0;
                  busy      <= 1'b1;
                  req_ready <= 1'b0;
                  if (req_len == '0) begin
                     req_done <= 1'b1;
                     state    <= DONE;
                  end else begin
                     state <= CALC;
                  end
               end
            end

            CALC: begin
               cur_blen    <= blen_calc;
               axi_awaddr  <= addr;
               axi_awlen   <= LSIZE'(blen_calc - BLW'(1));
               axi_awvalid <= can_issue;
               state       <= ISSUE;
            end

            ISSUE: begin
               if (aw_hs) begin
                  axi_awvalid <= 1'b0;
                  addr        <= addr + (ASIZE'(cur_blen) << BSH);
                  remaining   <= remaining - RLSIZE'(cur_blen);
                  state       <= (remaining == RLSIZE'(cur_blen)) ? DRAIN : CALC;
               end else if (!axi_awvalid) begin
                  axi_awvalid <= can_issue;
               end
            end

            DRAIN: begin
               if ((outstanding == '0) && q_empty) begin
                  req_done <= 1'b1;
                  req_err  <= err;
                  state    <= DONE;
               end
            end

            DONE: begin
               busy      <= 1'b0;
               req_ready <= 1'b1;
               state     <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

   // wcnt is the beat index inside the burst at the head of the length queue.
   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         wcnt <= '0;
      end else if (w_hs) begin
         wcnt <= axi_wlast ? '0 : wcnt + BLW'(1);
      end
   end

   axi_len_fifo #(
      .WIDTH (BLW),
      .DEPTH (MAX_OUTSTANDING)
   ) len_fifo (
      .clk       (axi_aclk),
      .reset     (axi_reset),
      .push      (q_push),
      .push_data (cur_blen),
      .pop       (q_pop),
      .empty     (q_empty),
      .full      (q_full),
      .head      (q_head)
   );

endmodule

// File: tb/tb_axi_inf_write_burst_core.sv
// Randomized bench for the write-burst controller: acts as AXI slave and W source,
// and predicts bursts, wlast, outstanding limits and status from address arithmetic.
module tb_axi_inf_write_burst_core;

   localparam int IDSIZE          = 3;
   localparam int ID              = 0;
   localparam int ASIZE           = 32;
   localparam int DSIZE           = 256;
   localparam int LSIZE           = 8;
   localparam int RLSIZE          = 24;
   localparam int MAX_BURST       = 16;
   localparam int MAX_OUTSTANDING = 4;
   localparam int BOUNDARY        = 4096;
   localparam int BPB             = DSIZE / 8;

   typedef struct {
      longint addr;
      int     len;
   } burst_t;

   logic              axi_aclk = 1'b0;
   logic              axi_reset = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic [ASIZE-1:0]  req_addr = '0;
   logic [RLSIZE-1:0] req_len = '0;
   logic              req_done;
   logic              req_err;
   logic              busy;
   logic              pull_data_en;
   logic [IDSIZE-1:0] axi_awid;
   logic [ASIZE-1:0]  axi_awaddr;
   logic [LSIZE-1:0]  axi_awlen;
   logic [2:0]        axi_awsize;
   logic [1:0]        axi_awburst;
   logic              axi_awlock;
   logic [3:0]        axi_awcache;
   logic [2:0]        axi_awprot;
   logic [3:0]        axi_awqos;
   logic              axi_awvalid;
   logic              axi_awready = 1'b0;
   logic              axi_wvalid = 1'b0;
   logic              axi_wready = 1'b0;
   logic              axi_wlast;
   logic              axi_bready;
   logic [IDSIZE-1:0] axi_bid = '0;
   logic [1:0]        axi_bresp = '0;
   logic              axi_bvalid = 1'b0;

   int     n_checks = 0;
   int     n_pass = 0;
   burst_t exp_aw[$];
   int     exp_wlen[$];
   int     model_out = 0;
   int     wbeat = 0;
   int     b_pending = 0;
   int     b_count = 0;
   int     aw_count = 0;
   int     done_count = 0;
   int     done_base = 0;
   bit     exp_err = 0;
   bit     last_err = 0;
   bit     slave_en = 0;
   bit     mon_en = 0;
   bit     aw_rand = 1;
   bit     b_hold = 0;
   int     err_mode = 0;
   bit     w_fire_d = 0;
   bit     b_fire_d = 0;

   axi_inf_write_burst_core #(
      .IDSIZE          (IDSIZE),
      .ID              (ID),
      .ASIZE           (ASIZE),
      .DSIZE           (DSIZE),
      .LSIZE           (LSIZE),
      .RLSIZE          (RLSIZE),
      .MAX_BURST       (MAX_BURST),
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .BOUNDARY        (BOUNDARY)
   ) dut (
      .axi_aclk     (axi_aclk),
      .axi_reset    (axi_reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .req_len      (req_len),
      .req_done     (req_done),
      .req_err      (req_err),
      .busy         (busy),
      .pull_data_en (pull_data_en),
      .axi_awid     (axi_awid),
      .axi_awaddr   (axi_awaddr),
      .axi_awlen    (axi_awlen),
      .axi_awsize   (axi_awsize),
      .axi_awburst  (axi_awburst),
      .axi_awlock   (axi_awlock),
      .axi_awcache  (axi_awcache),
      .axi_awprot   (axi_awprot),
      .axi_awqos    (axi_awqos),
      .axi_awvalid  (axi_awvalid),
      .axi_awready  (axi_awready),
      .axi_wvalid   (axi_wvalid),
      .axi_wready   (axi_wready),
      .axi_wlast    (axi_wlast),
      .axi_bready   (axi_bready),
      .axi_bid      (axi_bid),
      .axi_bresp    (axi_bresp),
      .axi_bvalid   (axi_bvalid)
   );

   always #5 axi_aclk = ~axi_aclk;

   initial begin
      #900000;
      $display("[TB] FAIL watchdog: got time limit, expected completion");
      $fatal(1, "[TB] simulation time limit reached");
   end

   task automatic check_output(input string tag, input longint actual, input longint expected);
      n_checks++;
      if (actual == expected) begin
         n_pass++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Reference split: walk the request, each burst takes min(left, cap, room to boundary).
   function automatic void plan_bursts(input logic [31:0] a, input int len);
      longint cur;
      int     rem;
      int     room;
      int     b;
      cur = longint'(a);
      rem = len;
      while (rem > 0) begin
         room = (BOUNDARY - int'(cur % BOUNDARY)) / BPB;
         b = rem;
         if (b > MAX_BURST) b = MAX_BURST;
         if (b > room) b = room;
         exp_aw.push_back('{cur, b});
         cur = (cur + longint'(b * BPB)) & 64'hFFFF_FFFF;
         rem -= b;
      end
   endfunction

   // Slave and W-source behaviour, updated shortly after each rising edge.
   always @(posedge axi_aclk) begin
      #2;
      if (!slave_en) begin
         axi_awready = 1'b0;
         axi_wvalid  = 1'b0;
         axi_wready  = 1'b0;
         axi_bvalid  = 1'b0;
         axi_bid     = '0;
         axi_bresp   = '0;
      end else begin
         axi_awready = aw_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
         if (!(axi_wvalid && !w_fire_d)) begin
            axi_wvalid = pull_data_en && ($urandom_range(0, 3) != 0);
         end
         axi_wready = ($urandom_range(0, 3) != 0);
         if (!(axi_bvalid && !b_fire_d)) begin
            axi_bvalid = 1'b0;
            if (!b_hold && b_pending > 0 && $urandom_range(0, 2) == 0) begin
               axi_bvalid = 1'b1;
               axi_bid    = IDSIZE'(ID);
               axi_bresp  = 2'b00;
               if (err_mode == 1 && $urandom_range(0, 7) == 0) begin
                  axi_bid = IDSIZE'(ID + 1);
               end else if (err_mode == 1 && $urandom_range(0, 5) == 0) begin
                  axi_bresp = 2'b10;
               end else if (err_mode == 2 && b_count == 1) begin
                  axi_bresp = 2'b10;
               end
            end
         end
      end
   end

   // Observe the cycle before each rising edge: outputs and handshakes are stable here.
   always @(negedge axi_aclk) begin
      burst_t b;
      w_fire_d = 1'b0;
      b_fire_d = 1'b0;
      if (mon_en) begin
         check_output("pull_data_en", pull_data_en, exp_wlen.size() != 0);
         check_output("bready", axi_bready, model_out != 0);
         check_output("wlast_level", axi_wlast,
                      (exp_wlen.size() != 0) && (wbeat == exp_wlen[0] - 1));
         if (axi_awvalid) begin
            check_output("aw_limit", model_out < MAX_OUTSTANDING, 1);
         end
         if (axi_awvalid && axi_awready) begin
            aw_count++;
            if (exp_aw.size() == 0) begin
               check_output("aw_unexpected", 1, 0);
            end else begin
               b = exp_aw.pop_front();
               check_output("awaddr", axi_awaddr, b.addr);
               check_output("awlen", axi_awlen, b.len - 1);
               exp_wlen.push_back(b.len);
               model_out++;
            end
         end
         if (axi_wvalid && axi_wready) begin
            w_fire_d = 1'b1;
            if (exp_wlen.size() == 0) begin
               check_output("w_unexpected", 1, 0);
            end else begin
               wbeat++;
               if (wbeat == exp_wlen[0]) begin
                  void'(exp_wlen.pop_front());
                  wbeat = 0;
                  b_pending++;
               end
            end
         end
         if (axi_bvalid && axi_bready) begin
            b_fire_d = 1'b1;
            if (axi_bid == IDSIZE'(ID)) begin
               model_out--;
               b_pending--;
               b_count++;
               if (axi_bresp != 2'b00) exp_err = 1'b1;
            end else begin
               exp_err = 1'b1;
            end
         end
         if (req_done) begin
            done_count++;
            last_err = req_err;
            check_output("req_err", req_err, exp_err);
            check_output("done_bursts_left", exp_aw.size(), 0);
            check_output("done_outstanding", model_out, 0);
         end
      end
   end

   task automatic apply_stimulus(input logic [31:0] a, input logic [23:0] len);
      int n;
      n = 0;
      while (!req_ready && n < 100) begin
         @(posedge axi_aclk);
         #1;
         n++;
      end
      check_output("req_ready", req_ready, 1);
      plan_bursts(a, int'(len));
      exp_err   = 1'b0;
      b_count   = 0;
      aw_count  = 0;
      done_base = done_count;
      req_addr  = a;
      req_len   = len;
      req_valid = 1'b1;
      @(posedge axi_aclk);
      #1;
      req_valid = 1'b0;
      check_output("busy_t1", busy, 1);
      check_output("req_ready_t1", req_ready, 0);
      if (len == 0) begin
         check_output("zero_len_done_t1", req_done, 1);
         check_output("zero_len_err_t1", req_err, 0);
      end else begin
         check_output("awvalid_t1", axi_awvalid, 0);
         @(posedge axi_aclk);
         #1;
         check_output("awvalid_t2", axi_awvalid, 1);
      end
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      while (done_count == done_base && n < budget) begin
         @(posedge axi_aclk);
         #1;
         n++;
      end
      check_output("req_done_count", done_count - done_base, 1);
   endtask

   initial begin
      $display("[TB] start");
      repeat (3) @(posedge axi_aclk);
      #1;
      check_output("rst_req_ready", req_ready, 1);
      check_output("rst_busy", busy, 0);
      check_output("rst_req_done", req_done, 0);
      check_output("rst_req_err", req_err, 0);
      check_output("rst_awvalid", axi_awvalid, 0);
      check_output("rst_wlast", axi_wlast, 0);
      check_output("rst_bready", axi_bready, 0);
      check_output("rst_pull", pull_data_en, 0);
      check_output("awsize", axi_awsize, $clog2(BPB));
      check_output("awburst", axi_awburst, 1);
      check_output("awid", axi_awid, ID);
      check_output("aw_attrs", {axi_awlock, axi_awcache, axi_awprot, axi_awqos}, 0);
      axi_reset = 1'b0;
      slave_en  = 1'b1;
      mon_en    = 1'b1;
      @(posedge axi_aclk);
      #1;

      $display("[TB] 40 beats from 0x0");
      apply_stimulus(32'h0, 24'd40);
      wait_done(2000);
      check_output("t1_aw_count", aw_count, 3);
      check_output("t1_err", last_err, 0);

      $display("[TB] 8 beats across the 4KB line");
      apply_stimulus(32'hFC0, 24'd8);
      wait_done(1000);
      check_output("t2_aw_count", aw_count, 2);

      $display("[TB] outstanding limit with B withheld");
      aw_rand = 1'b0;
      b_hold  = 1'b1;
      apply_stimulus(32'h0, 24'd128);
      repeat (40) @(posedge axi_aclk);
      #1;
      check_output("t3_aw_held_count", aw_count, MAX_OUTSTANDING);
      check_output("t3_awvalid_held", axi_awvalid, 0);
      b_hold = 1'b0;
      wait_done(4000);
      check_output("t3_aw_count", aw_count, 8);
      aw_rand = 1'b1;

      $display("[TB] error on the second B");
      err_mode = 2;
      apply_stimulus(32'h2000, 24'd48);
      wait_done(3000);
      check_output("t4_err_set", last_err, 1);
      err_mode = 0;
      apply_stimulus(32'h3000, 24'd16);
      wait_done(1000);
      check_output("t4_err_clear", last_err, 0);

      $display("[TB] zero-length request");
      apply_stimulus(32'h100, 24'd0);
      wait_done(10);
      repeat (3) @(posedge axi_aclk);
      #1;
      check_output("t5_aw_count", aw_count, 0);

      $display("[TB] reset during the second burst");
      apply_stimulus(32'h0, 24'd64);
      begin
         int n;
         n = 0;
         while (aw_count < 1 && n < 200) begin
            @(posedge axi_aclk);
            #1;
            n++;
         end
      end
      check_output("t6_first_aw", aw_count, 1);
      @(posedge axi_aclk);
      #1;
      mon_en    = 1'b0;
      slave_en  = 1'b0;
      axi_reset = 1'b1;
      @(posedge axi_aclk);
      #1;
      check_output("t6_req_ready", req_ready, 1);
      check_output("t6_busy", busy, 0);
      check_output("t6_req_done", req_done, 0);
      check_output("t6_req_err", req_err, 0);
      check_output("t6_awvalid", axi_awvalid, 0);
      check_output("t6_wlast", axi_wlast, 0);
      check_output("t6_bready", axi_bready, 0);
      check_output("t6_pull", pull_data_en, 0);
      axi_reset = 1'b0;
      exp_aw.delete();
      exp_wlen.delete();
      model_out = 0;
      wbeat     = 0;
      b_pending = 0;
      @(posedge axi_aclk);
      #1;
      slave_en = 1'b1;
      mon_en   = 1'b1;
      apply_stimulus(32'h40, 24'd20);
      wait_done(1000);
      check_output("t6_after_err", last_err, 0);

      $display("[TB] randomized requests");
      err_mode = 1;
      for (int i = 0; i < 10; i++) begin
         logic [31:0] a;
         int          len;
         a = $urandom;
         a[4:0] = 5'd0;
         if (i % 3 == 1) a[11:5] = 7'h7F - 7'($urandom_range(0, 4));
         if (i == 4) a = 32'hFFFF_FFC0;
         len = $urandom_range(1, 90);
         if (i == 6) len = 0;
         if (i == 8) len = 300;
         apply_stimulus(a, 24'(len));
         wait_done(len * 30 + 200);
      end

      repeat (5) @(posedge axi_aclk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/axi_inf_write_burst_core.md
Name: axi_inf_write_burst_core

Overview:
- Next-generation AXI4 write-channel controller. Accepts one long write request (arbitrary beat count) and splits it into AXI INCR bursts.
- Each burst is capped at MAX_BURST beats and never crosses a BOUNDARY-byte address boundary.
- Keeps up to MAX_OUTSTANDING AW bursts in flight, generates wlast from a per-burst length queue, and reports aggregated B-response status.
- Sits between the VDMA frame-line scheduler and the AXI interconnect. The external write-data FIFO drives axi_wvalid.

Parameters:
- IDSIZE, 3, AXI ID width.
- ID, 0, AXI ID driven on awid and matched on bid.
- ASIZE, 32, address width.
- DSIZE, 256, data width in bits (power of 2, ≥8); BPB = DSIZE/8 bytes per beat.
- LSIZE, 8, awlen width.
- RLSIZE, 24, request length width (beats).
- MAX_BURST, 16, max beats per burst (≤ 2^LSIZE, ≤256).
- MAX_OUTSTANDING, 4, max AW bursts awaiting B (power of 2).
- BOUNDARY, 4096, no-cross byte boundary (power of 2, ≥ BPB).

Ports:
- axi_aclk in 1: clock.
- axi_reset in 1: reset. One clock; reset is synchronous and active-high.
- req_valid in 1: request strobe.
- req_ready out 1: high in IDLE only.
- req_addr in ASIZE: start byte address, BPB-aligned.
- req_len in RLSIZE: total beats.
- req_done out 1: one-cycle pulse at request completion.
- req_err out 1: valid with req_done; 1 if any BRESP≠OKAY or a foreign bid was seen.
- busy out 1: high from accept until req_done.
- pull_data_en out 1: data path may present W beats.
- axi_awid out IDSIZE; axi_awaddr out ASIZE; axi_awlen out LSIZE; axi_awsize out 3; axi_awburst out 2; axi_awlock out 1; axi_awcache out 4; axi_awprot out 3; axi_awqos out 4; axi_awvalid out 1; axi_awready in 1: AW channel.
- axi_wvalid in 1; axi_wready in 1; axi_wlast out 1: W channel.
- axi_bready out 1; axi_bid in IDSIZE; axi_bresp in 2; axi_bvalid in 1: B channel.

Behaviour:
- Reset values: req_ready=1, req_done=0, req_err=0, busy=0, pull_data_en=0, axi_awvalid=0, axi_wlast=0, axi_bready=0, all counters and the queue cleared. Reset mid-burst aborts immediately; AW/W protocol completion is not guaranteed (documented limitation).
- Constant outputs: awid=ID, awsize=clog2(BPB), awburst=01, awlock/cache/prot/qos all 0.
- FSM states: IDLE, CALC, ISSUE, DRAIN, DONE.
- IDLE: on req_valid, latch addr and len (cycle T). If len=0, go to DONE: req_done=1 at T+1, err=0, no AXI traffic. Otherwise go to CALC.
- CALC (one cycle): blen = min(remaining, MAX_BURST, (BOUNDARY − addr mod BOUNDARY)/BPB). Register awaddr and awlen=blen−1. Go to ISSUE. First awvalid is asserted at T+2.
- ISSUE: awvalid=1 only while outstanding < MAX_OUTSTANDING; otherwise hold with awvalid=0. awaddr/awlen stay stable while awvalid=1.
- On AW handshake: push blen to the length queue, outstanding+1, addr += blen·BPB, remaining −= blen. Then go to CALC if remaining>0, else DRAIN.
- DRAIN: wait until outstanding=0 and the queue is empty, then go to DONE. DONE pulses req_done with req_err, then returns to IDLE.
- Length queue: sub-module, depth MAX_OUTSTANDING. Simultaneous push and pop is legal. It never overflows because pushes are gated by outstanding.
- W path:
  - pull_data_en = queue non-empty (registered).
  - wcnt counts W handshakes (axi_wvalid & axi_wready).
  - axi_wlast = queue non-empty && wcnt == head−1. Driven from registers only; no input-to-output combinational path.
  - On a handshake with wlast: pop the queue and clear wcnt.
  - W beats may precede their AW handshake only if already queued. W never runs ahead of queued bursts.
- B path: axi_bready=1 while outstanding>0.
  - B handshake with bid=ID: outstanding−1; bresp≠00 sets sticky err.
  - B handshake with bid≠ID: not counted; sets err.
  - Simultaneous AW and B handshake: outstanding unchanged.
- Sticky err clears on the next request accept.
- Arithmetic: remaining is RLSIZE bits; address wraps modulo 2^ASIZE without error.

Decomposition:
- Package axi_inf_pkg holds: the FSM state enum typedef, AXI constants (BURST_INCR, RESP_OKAY, LOCK/CACHE/PROT/QOS defaults), and a clog2-based awsize function.
- One sub-module: axi_len_fifo (synchronous FIFO, width LSIZE+1, depth MAX_OUTSTANDING, push/pop/empty/full/head).

Test Plan:
1. addr=0x0, len=40, DSIZE=256, MAX_BURST=16 → AW bursts at 0x000/0x200/0x400 with awlen 15/15/7; wlast on beats 16, 32 and 40; one req_done, err=0.
2. addr=0xFC0, len=8 (BPB=32) → awlen=1 at 0xFC0 (2 beats up to 0x1000), then awlen=5 at 0x1000; no burst crosses 4KB.
3. awready=1, B responses withheld, len=128 → exactly 4 AW handshakes, then awvalid=0 until the first B, then issue resumes.
4. Second B returns bresp=10 → req_err=1 with req_done; a subsequent clean request returns err=0.
5. len=0 → req_done at T+1, err=0, no awvalid ever asserted.
6. Assert axi_reset during the second burst → next cycle all outputs at reset values, req_ready=1; a new request completes normally.
